// File: rtl/encoder_speed_meter.sv
// rtl/encoder_speed_meter.sv - windowed quadrature speed meter with moving average
// Drives the encoder counter's window clear and publishes a signed per-window speed.
module encoder_speed_meter #(
  parameter int WINDOW_CYCLES = 17500000,
  parameter int COUNT_W       = 8,
  parameter int AVG_LOG2      = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [COUNT_W-1:0]        count_in,
  input  logic                      dir_in,
  output logic                      tick,
  output logic signed [COUNT_W:0]   speed,
  output logic                      speed_valid,
  output logic                      sat
);

  localparam int TIMER_W = $clog2(WINDOW_CYCLES);
  localparam int DEPTH   = 1 << AVG_LOG2;
  localparam int SUM_W   = COUNT_W + 1 + AVG_LOG2;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(WINDOW_CYCLES - 1);

  generate
    if (WINDOW_CYCLES < 4) begin : g_bad_window
      $error("encoder_speed_meter: WINDOW_CYCLES must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                capture;
  logic                tick_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // A window that reaches its last cycle is captured even if enable falls on that cycle.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    tick_c  = 1'b1;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FLUSH;
      end
      FLUSH: begin
        tick_c  = 1'b0;
        state_d = enable ? RUN : IDLE;
      end
      RUN: begin
        if (timer_q == LAST) begin
          tick_c  = 1'b0;
          capture = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (!enable) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick = tick_c;

  logic signed [COUNT_W:0]   mag;
  logic signed [COUNT_W:0]   raw_d, raw_q;
  logic                      cap_v, acc_v, sat_pend;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [COUNT_W:0]   hist [DEPTH];

  assign mag   = {1'b0, count_in};
  assign raw_d = dir_in ? -mag : mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q       <= '0;
      cap_v       <= 1'b0;
      acc_v       <= 1'b0;
      sat_pend    <= 1'b0;
      sum_q       <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      sat         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      cap_v       <= capture;
      acc_v       <= cap_v;
      speed_valid <= acc_v;
      if (capture) begin
        raw_q    <= raw_d;
        sat_pend <= &count_in;
      end
      // Running sum replaces the oldest sample; width covers DEPTH full-scale samples.
      if (cap_v) begin
        sum_q <= sum_q
               + {{AVG_LOG2{raw_q[COUNT_W]}}, raw_q}
               - {{AVG_LOG2{hist[DEPTH-1][COUNT_W]}}, hist[DEPTH-1]};
        for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= raw_q;
      end
      // Dropping the low bits of a two's complement sum floors toward -inf.
      if (acc_v) begin
        speed <= sum_q[SUM_W-1:AVG_LOG2];
        sat   <= sat_pend;
      end
    end
  end

endmodule

// File: tb/tb_encoder_speed_meter.sv
// tb/tb_encoder_speed_meter.sv - directed bench for encoder_speed_meter
// Behavioural encoder counter feeds count_in and clears on tick.
module tb_encoder_speed_meter;

  localparam int WIN = 100;

  logic              clk = 1'b0;
  logic              reset_n, enable, dir_in;
  logic [7:0]        count_in;
  logic              tick, speed_valid, sat;
  logic signed [8:0] speed;

  logic [7:0] enc_cnt = 8'd0;
  logic [7:0] ppw, fixed_val;
  logic       fixed_mode;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, tick_cnt = 0, sv_cnt = 0;
  int last_tick = 0, en_cyc = 0, base_t = 0, base_v = 0;

  always #5 clk = ~clk;

  encoder_speed_meter #(.WINDOW_CYCLES(WIN), .COUNT_W(8), .AVG_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .count_in(count_in),
    .dir_in(dir_in), .tick(tick), .speed(speed), .speed_valid(speed_valid), .sat(sat)
  );

  assign count_in = fixed_mode ? fixed_val : enc_cnt;

  // Counter clear wins over a pulse on the tick cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!tick) enc_cnt <= 8'd0;
    else if (enc_cnt < ppw) enc_cnt <= enc_cnt + 8'd1;
  end

  always @(negedge clk) begin
    if (!tick) tick_cnt <= tick_cnt + 1;
    if (speed_valid) sv_cnt <= sv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_spd(input string tag, input logic [8:0] exp);
    n_cmp++;
    assert (speed === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, speed, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_tick"}, 32'(tick), 32'd1);
    check({tag, "_sv"}, 32'(speed_valid), 32'd0);
    check({tag, "_sat"}, 32'(sat), 32'd0);
    check_spd({tag, "_speed"}, 9'h000);
  endtask

  task automatic tick_wait();
    bit found = 1'b0;
    for (int i = 0; i < 250 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b0) found = 1'b1;
    end
    check("tick_seen", 32'(found), 32'd1);
  endtask

  task automatic flush();
    tick_wait();
    check("flush_delay", 32'(cyc - en_cyc), 32'd1);
    last_tick = cyc;
    @(negedge clk);
    check("flush_width", 32'(tick), 32'd1);
  endtask

  task automatic window(input logic [8:0] exp_spd, input logic exp_sat);
    tick_wait();
    check("tick_period", 32'(cyc - last_tick), 32'(WIN));
    last_tick = cyc;
    @(negedge clk);
    @(negedge clk);
    check("sv_early", 32'(speed_valid), 32'd0);
    @(negedge clk);
    check("sv_strobe", 32'(speed_valid), 32'd1);
    check_spd("speed", exp_spd);
    check("sat", 32'(sat), 32'(exp_sat));
    @(negedge clk);
    check("sv_width", 32'(speed_valid), 32'd0);
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (2) @(negedge clk);
    reset_vals("rst");
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; dir_in = 1'b0;
    ppw = 8'd0; fixed_mode = 1'b0; fixed_val = 8'd0;

    // Idle after reset
    hard_reset();
    base_t = tick_cnt; base_v = sv_cnt;
    repeat (500) @(negedge clk);
    check("idle_ticks", 32'(tick_cnt - base_t), 32'd0);
    check("idle_strobes", 32'(sv_cnt - base_v), 32'd0);
    reset_vals("idle");

    // 20 pulses per window, clockwise
    ppw = 8'd20; enable = 1'b1; en_cyc = cyc;
    flush();
    window(9'd5, 1'b0);
    window(9'd10, 1'b0);
    window(9'd15, 1'b0);
    window(9'd20, 1'b0);
    window(9'd20, 1'b0);

    // Reset on the capture cycle (timer = 99)
    tick_wait();
    base_v = sv_cnt;
    reset_n = 1'b0;
    #1;
    reset_vals("rst99");
    @(negedge clk);
    reset_n = 1'b1; en_cyc = cyc;
    flush();
    check("rst99_no_strobe", 32'(sv_cnt - base_v), 32'd0);

    // Reset one cycle after the capture edge
    tick_wait();
    check("tick_period", 32'(cyc - last_tick), 32'(WIN));
    @(negedge clk);
    base_v = sv_cnt;
    reset_n = 1'b0;
    #1;
    reset_vals("rstc1");
    @(negedge clk);
    reset_n = 1'b1; en_cyc = cyc;
    flush();
    check("rstc1_no_strobe", 32'(sv_cnt - base_v), 32'd0);
    window(9'd5, 1'b0);
    window(9'd10, 1'b0);
    window(9'd15, 1'b0);
    window(9'd20, 1'b0);

    // Full-scale count then 10
    hard_reset();
    fixed_mode = 1'b1; fixed_val = 8'd255; dir_in = 1'b0;
    enable = 1'b1; en_cyc = cyc;
    flush();
    window(9'd63, 1'b1);
    fixed_val = 8'd10;
    window(9'd66, 1'b0);

    // 12 pulses per window, counter-clockwise
    hard_reset();
    fixed_mode = 1'b0; ppw = 8'd12; dir_in = 1'b1;
    enable = 1'b1; en_cyc = cyc;
    flush();
    window(9'h1FD, 1'b0);
    window(9'h1FA, 1'b0);
    window(9'h1F7, 1'b0);
    window(9'h1F4, 1'b0);

    // Enable dropped 50 cycles into a window, restored 30 cycles later
    repeat (46) @(negedge clk);
    base_t = tick_cnt; base_v = sv_cnt;
    enable = 1'b0;
    repeat (30) @(negedge clk);
    check("drop_ticks", 32'(tick_cnt - base_t), 32'd0);
    check("drop_strobes", 32'(sv_cnt - base_v), 32'd0);
    check_spd("drop_speed_hold", 9'h1F4);
    enable = 1'b1; en_cyc = cyc;
    flush();
    repeat (50) @(negedge clk);
    check_spd("reen_speed_hold", 9'h1F4);
    window(9'h1F4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_speed_meter.md
Name: encoder_speed_meter

Overview:
- Consumes the per-window pulse count and direction from the quadrature encoder counter.
- Generates that counter's active-low window-reset tick on a fixed period.
- Captures the count at each window boundary, applies the direction sign, and averages over the last 2^AVG_LOG2 windows.
- Publishes a signed speed word with a one-cycle valid strobe for the downstream velocity controller.

Parameters:
WINDOW_CYCLES, 17500000, window length in clk cycles (350 ms at 50 MHz); minimum 4
COUNT_W, 8, width of count_in
AVG_LOG2, 2, log2 of the moving-average depth (depth = 4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  measurement enable (level)
count_in  in  COUNT_W  pulse count from the encoder counter (unsigned)
dir_in  in  1  encoder direction: 0 = cw (positive), 1 = ccw (negative)
tick  out  1  window reset to the encoder counter, active low, one cycle wide
speed  out  COUNT_W+1  signed averaged counts per window (two's complement)
speed_valid  out  1  one-cycle strobe when speed updates
sat  out  1  count_in reached its all-ones value in the latest window; updates with speed_valid

Behaviour:
- Reset: one clock; reset_n is asynchronous, active-low.
  - Reset values: tick=1, speed=0, speed_valid=0, sat=0, timer=0, history and sum cleared, state=IDLE.
  - Assertion mid-window aborts immediately; no tick and no strobe are produced.
- FSM states: IDLE, FLUSH, RUN.
  - IDLE: tick=1, timer held at 0. enable=1 -> FLUSH.
  - FLUSH: exactly one cycle. tick=0, no capture; discards counts accumulated while idle. Next state is RUN, with timer=0.
  - RUN: timer increments each cycle.
    - On the cycle timer==WINDOW_CYCLES-1: tick=0, count_in and dir_in are captured on that clk edge, and timer wraps to 0.
    - The encoder counter clears on the same edge, so the pre-clear value is captured.
    - Result: consecutive captures exactly WINDOW_CYCLES apart.
  - enable=0 in any state -> IDLE next cycle.
    - No capture for the partial window.
    - History, sum and speed are retained.
    - Re-enable always passes through FLUSH.
- Arithmetic pipeline, counting from capture edge C:
  - Edge C: raw = dir_in ? -count_in : +count_in, a (COUNT_W+1)-bit signed value; range -255..+255 for COUNT_W=8. sat_pending = (count_in == all-ones).
  - Edge C+1:
    - sum <= sum + raw - oldest.
    - The history shift register (depth 2^AVG_LOG2) shifts raw in.
    - sum width is COUNT_W+1+AVG_LOG2, so it never overflows.
  - Edge C+2:
    - speed <= sum >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
    - sat <= sat_pending.
    - speed_valid=1 for exactly this one cycle.
  - Latency from the capture edge to speed_valid high is 2 cycles.
  - The pipeline completes even if enable drops after capture. A reset during the pipeline discards it.
- Warm-up: history starts at zero after reset, so the first 2^AVG_LOG2-1 outputs are partial averages. No separate flag.
- Encoder edge coincident with the tick cycle: the downstream counter drops it (its clear has priority). This is an accepted ±1 count error per window and is not compensated.
- sat is informational only. The count is not extended; speed uses the saturated value as-is.
- WINDOW_CYCLES < 4 is illegal; enforced by a synthesis-time check.

Test Plan:
All scenarios use WINDOW_CYCLES=100, COUNT_W=8, AVG_LOG2=2, and a behavioural encoder model driving count_in.

- Reset release, enable=0 for 500 cycles -> tick stays 1, speed=0, speed_valid never asserts, sat=0.
- enable=1 -> tick low exactly one cycle (FLUSH). Then model supplies 20 pulses/window with dir=0 -> tick low every 100 cycles; speed_valid 2 cycles after each capture; speed=5,10,15,20,20.
- From reset, 12 pulses/window with dir=1 -> speed=-3,-6,-9,-12 (0x1FD,0x1FA,0x1F7,0x1F4 in 9 bits).
- Window with count_in=255, dir=0, then a window with 10 -> first strobe sat=1, speed=63; next strobe sat=0, speed=66.
- enable dropped 50 cycles into a window, re-raised 30 cycles later -> no tick and no strobe for the partial window. One FLUSH tick 1 cycle after re-enable. Next capture tick 100 cycles after FLUSH. Prior speed is held throughout.
- reset_n pulsed low at timer=99 and at capture edge+1 -> no speed_valid. All outputs return to reset values asynchronously. History is cleared, so the next run restarts the 5,10,15,20 sequence.
